gtech_gate_exerciser: RTL and testbench

//  Drives and checks a 4-input/1-output GTECH complex gate (AOI22 by default).
//  On START it applies all 16 input vectors {A,B,C,D} = 0..15 in ascending order.
//  For each vector it samples the gate output and compares it with a parameterised truth table.

---
 rtl/gtech_gate_exerciser_if.sv | 45 ++++
 rtl/gtech_gate_exerciser.sv | 107 ++++++++++
 tb/tb_gtech_gate_exerciser.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gtech_gate_exerciser_if.sv
// Exerciser <-> gate-under-test bundle: stimulus, gate output, run control and results.
interface gtech_gate_exerciser_if;
  logic       START;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       ZIN;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [4:0] ERR_CNT;
  logic [3:0] FAIL_VEC;
  logic       FAIL_VALID;

  modport master (
    input  START,
    input  ZIN,
    output A,
    output B,
    output C,
    output D,
    output BUSY,
    output DONE,
    output PASS,
    output ERR_CNT,
    output FAIL_VEC,
    output FAIL_VALID
  );

  modport slave (
    output START,
    output ZIN,
    input  A,
    input  B,
    input  C,
    input  D,
    input  BUSY,
    input  DONE,
    input  PASS,
    input  ERR_CNT,
    input  FAIL_VEC,
    input  FAIL_VALID
  );
endinterface

// File: rtl/gtech_gate_exerciser.sv
// Sweeps all 16 input vectors of a 4-in/1-out gate and checks ZIN
// against the TRUTH table; reports mismatch count and first failing vector.
module gtech_gate_exerciser #(
  parameter logic [15:0] TRUTH      = 16'h0777,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                   CP,
  input  logic                   RST,
  gtech_gate_exerciser_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);
  localparam state_t FIRST = (SETTLE == 4'd0) ? SAMPLE : HOLD;

  state_t     state;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err;
  logic [3:0] fvec;
  logic       fvalid;

  logic       mis;
  logic [4:0] err_nxt;

  always_comb begin
    mis     = 1'b0;
    err_nxt = err;
    if (state == SAMPLE) begin
      mis     = (bus.ZIN != TRUTH[vec]);
      err_nxt = err + {4'd0, mis};
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state  <= IDLE;
      vec    <= 4'd0;
      cnt    <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      err    <= 5'd0;
      fvec   <= 4'd0;
      fvalid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            vec    <= 4'd0;
            cnt    <= SETTLE;
            err    <= 5'd0;
            fvec   <= 4'd0;
            fvalid <= 1'b0;
            pass   <= 1'b0;
            busy   <= 1'b1;
            state  <= FIRST;
          end
        end
        HOLD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          err <= err_nxt;
          if (mis && !fvalid) begin
            fvec   <= vec;
            fvalid <= 1'b1;
          end
          if (vec != 4'd15) begin
            vec   <= vec + 4'd1;
            cnt   <= SETTLE;
            state <= FIRST;
          end else begin
            vec   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 5'd0);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A          = vec[3];
  assign bus.B          = vec[2];
  assign bus.C          = vec[1];
  assign bus.D          = vec[0];
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.PASS       = pass;
  assign bus.ERR_CNT    = err;
  assign bus.FAIL_VEC   = fvec;
  assign bus.FAIL_VALID = fvalid;

endmodule

// File: tb/tb_gtech_gate_exerciser.sv
// Bench for gtech_gate_exerciser: two instances (SETTLE_CYC=1 and 0) driving
// a modelled gate whose truth table the bench chooses per run.
module tb_gtech_gate_exerciser;

  localparam logic [15:0] AOI22 = 16'h0777;

  logic        CP = 1'b0;
  logic        RST = 1'b1;
  logic        st = 1'b0;
  int          sel = 1;
  logic [15:0] gt = AOI22;

  int n_chk = 0;
  int n_fail = 0;

  gtech_gate_exerciser_if if1 ();
  gtech_gate_exerciser_if if0 ();

  gtech_gate_exerciser #(.TRUTH(AOI22), .SETTLE_CYC(1)) dut1 (
    .CP(CP), .RST(RST), .bus(if1.master)
  );
  gtech_gate_exerciser #(.TRUTH(AOI22), .SETTLE_CYC(0)) dut0 (
    .CP(CP), .RST(RST), .bus(if0.master)
  );

  always #5 CP = ~CP;

  assign if1.START = st & (sel == 1);
  assign if0.START = st & (sel == 0);
  assign if1.ZIN   = gt[{if1.A, if1.B, if1.C, if1.D}];
  assign if0.ZIN   = gt[{if0.A, if0.B, if0.C, if0.D}];

  logic       o_busy, o_done, o_pass, o_fv;
  logic [4:0] o_err;
  logic [3:0] o_fvec, o_vec;

  always_comb begin
    o_busy = if0.BUSY;
    o_done = if0.DONE;
    o_pass = if0.PASS;
    o_fv   = if0.FAIL_VALID;
    o_err  = if0.ERR_CNT;
    o_fvec = if0.FAIL_VEC;
    o_vec  = {if0.A, if0.B, if0.C, if0.D};
    if (sel == 1) begin
      o_busy = if1.BUSY;
      o_done = if1.DONE;
      o_pass = if1.PASS;
      o_fv   = if1.FAIL_VALID;
      o_err  = if1.ERR_CNT;
      o_fvec = if1.FAIL_VEC;
      o_vec  = {if1.A, if1.B, if1.C, if1.D};
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int first_set(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_pass"}, 32'(o_pass), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    chk({tag, "_fvec"}, 32'(o_fvec), 0);
    chk({tag, "_fv"}, 32'(o_fv), 0);
    chk({tag, "_vec"}, 32'(o_vec), 0);
  endtask

  task automatic kick();
    @(negedge CP);
    st = 1'b1;
    @(negedge CP);
    st = 1'b0;
  endtask

  // Called at the first negedge after the START edge; ends at the DONE negedge.
  task automatic body(input int s, input string tag);
    int L;
    logic [15:0] m;
    int ne;
    L  = 16 * (s + 1);
    m  = gt ^ AOI22;
    ne = $countones(m);
    chk({tag, "_clr_err"}, 32'(o_err), 0);
    chk({tag, "_clr_fv"}, 32'(o_fv), 0);
    chk({tag, "_clr_pass"}, 32'(o_pass), 0);
    for (int k = 0; k < L; k++) begin
      chk({tag, "_busy"}, 32'(o_busy), 1);
      chk({tag, "_nodone"}, 32'(o_done), 0);
      chk({tag, "_vec"}, 32'(o_vec), 32'(k / (s + 1)));
      @(negedge CP);
    end
    chk({tag, "_done"}, 32'(o_done), 1);
    chk({tag, "_busy_end"}, 32'(o_busy), 0);
    chk({tag, "_vec_end"}, 32'(o_vec), 0);
    chk({tag, "_err"}, 32'(o_err), 32'(ne));
    chk({tag, "_pass"}, 32'(o_pass), 32'(ne == 0));
    chk({tag, "_fv"}, 32'(o_fv), 32'(ne != 0));
    if (ne != 0) chk({tag, "_fvec"}, 32'(o_fvec), 32'(first_set(m)));
  endtask

  initial begin
    int s;
    repeat (3) @(negedge CP);
    sel = 1;
    #1 chk_idle_zero("rst1");
    sel = 0;
    #1 chk_idle_zero("rst0");
    RST = 1'b0;

    sel = 1; gt = AOI22;     kick(); body(1, "t1_good");
    @(negedge CP);
    chk("t1_done_pulse", 32'(o_done), 0);
    chk("t1_pass_held", 32'(o_pass), 1);
    gt = 16'h0000;           kick(); body(1, "t2_tie0");
    chk("t2_err9", 32'(o_err), 9);
    gt = 16'hFFFF;           kick(); body(1, "t2_tie1");
    chk("t2_fvec3", 32'(o_fvec), 3);
    gt = ~AOI22;             kick(); body(1, "t3_inv");
    chk("t3_err16", 32'(o_err), 16);

    sel = 0; gt = AOI22;     kick(); body(0, "t4_good0");
    gt = 16'h0000;           kick(); body(0, "t4_tie0");

    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 1);
      s   = (sel == 1) ? 1 : 0;
      gt  = 16'($urandom);
      kick();
      body(s, "rnd");
    end

    sel = 1; gt = AOI22;
    kick();
    for (int k = 0; k < 18; k++) begin
      chk("t5_vec", 32'(o_vec), 32'(k / 2));
      chk("t5_busy", 32'(o_busy), 1);
      if (k == 10) st = 1'b1;
      if (k == 11) st = 1'b0;
      @(negedge CP);
    end
    chk("t5_vec9", 32'(o_vec), 9);
    RST = 1'b1;
    @(negedge CP);
    RST = 1'b0;
    chk_idle_zero("t5_abort");
    repeat (3) @(negedge CP);
    chk_idle_zero("t5_idle");
    gt = 16'h00F0;
    kick(); body(1, "t5_rerun");

    gt = 16'h0000;
    kick(); body(1, "t6_first");
    st = 1'b1;
    gt = AOI22;
    @(negedge CP);
    st = 1'b0;
    chk("t6_restart_busy", 32'(o_busy), 1);
    chk("t6_restart_done", 32'(o_done), 0);
    body(1, "t6_second");

    @(negedge CP);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
